// File: rtl/stress_accumulator.sv
// Stress level: synchronized stimulus edges add a saturating step, periodic ticks decay it.
// Optional STRESS_SLEEP_DECAY_EN halves the decay period while asleep is high.
module stress_accumulator #(
  parameter int N            = 7,
  parameter int STIM_STEP    = 8,
  parameter int DECAY_PERIOD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stimulus,
  input  logic         asleep,
  output logic [N-1:0] stress_level,
  output logic [1:0]   stress_indicator,
  output logic [1:0]   stress_state,
  output logic         panic
);

  localparam int CW = $clog2(DECAY_PERIOD);

  localparam logic [CW-1:0] CNT_LAST = CW'(DECAY_PERIOD - 1);
  localparam logic [N:0]    STEP     = (N+1)'(STIM_STEP);
  localparam logic [N:0]    TH_TENSE = (N+1)'(64);
  localparam logic [N:0]    TH_PANIC = (N+1)'(112);
  localparam logic [N:0]    TH_UNPAN = (N+1)'(80);
  localparam logic [N:0]    TH_CALM  = (N+1)'(32);

  typedef enum logic [1:0] {
    CALM  = 2'b00,
    TENSE = 2'b01,
    PANIC = 2'b10,
    BAD   = 2'b11
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_hist;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_level;
  state_t        r_state;
  logic          r_panic;

  logic          w_event;
  logic          w_tick;
  logic [N:0]    w_sum;
  logic [N-1:0]  w_sat;
  logic [N:0]    w_lvl;
  state_t        w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= stimulus;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_event = r_sync2 & ~r_hist;

`ifdef STRESS_SLEEP_DECAY_EN
  localparam logic [CW-1:0] CNT_HALF = CW'(DECAY_PERIOD / 2 - 1);

  assign w_tick = asleep ? (r_cnt == CNT_HALF)
                         : (r_cnt == CNT_LAST);
`else
  logic w_unused;

  assign w_unused = asleep;
  assign w_tick   = (r_cnt == CNT_LAST);
`endif

  // An event restarts the decay phase, swallowing a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_event || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_sum = {1'b0, r_level} + STEP;
  assign w_sat = w_sum[N] ? '1 : w_sum[N-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else if (w_event) begin
      r_level <= w_sat;
    end else if (w_tick && (r_level != '0)) begin
      r_level <= r_level - N'(1);
    end
  end

  assign w_lvl = {1'b0, r_level};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      CALM:    if (w_lvl >= TH_TENSE) w_next = TENSE;
      TENSE: begin
        if (w_lvl >= TH_PANIC)     w_next = PANIC;
        else if (w_lvl < TH_CALM)  w_next = CALM;
      end
      PANIC:   if (w_lvl < TH_UNPAN) w_next = TENSE;
      default: w_next = CALM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CALM;
      r_panic <= 1'b0;
    end else begin
      r_state <= w_next;
      r_panic <= (w_next == PANIC);
    end
  end

  assign stress_level     = r_level;
  assign stress_indicator = r_level[N-1 -: 2];
  assign stress_state     = r_state;
  assign panic            = r_panic;

endmodule

// File: tb/tb_stress_accumulator.sv
// Bench for stress_accumulator: cycle model feeds a scoreboard queue,
// plus directed checks on saturation, decay timing, reset and sleep decay.
module tb_stress_accumulator;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       stimulus = 1'b0;
  logic       asleep   = 1'b0;
  logic [6:0] stress_level;
  logic [1:0] stress_indicator;
  logic [1:0] stress_state;
  logic       panic;

  int n_chk = 0;
  int n_err = 0;

`ifdef STRESS_SLEEP_DECAY_EN
  localparam int SLP_CYC = 128;
`else
  localparam int SLP_CYC = 256;
`endif

  typedef struct packed {
    logic [6:0] lvl;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];

  stress_accumulator dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stimulus         (stimulus),
    .asleep           (asleep),
    .stress_level     (stress_level),
    .stress_indicator (stress_indicator),
    .stress_state     (stress_state),
    .panic            (panic)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    stimulus = 1'b1;
    step(2);
    stimulus = 1'b0;
    step(2);
  endtask

  function automatic int next_mood(input int st, input int lvl);
    case (st)
      0:       return (lvl >= 64) ? 1 : 0;
      1:       return (lvl >= 112) ? 2 : ((lvl < 32) ? 0 : 1);
      2:       return (lvl < 80) ? 1 : 2;
      default: return 0;
    endcase
  endfunction

  int   m_s1, m_s2, m_h, m_cnt, m_lvl, m_st;
  int   c_lvl, c_cnt, c_st, per;
  logic c_ev, c_tk;

  always_comb begin
    c_ev  = (m_s2 == 1) && (m_h == 0);
    per   = 16;
`ifdef STRESS_SLEEP_DECAY_EN
    if (asleep) per = 8;
`endif
    c_tk  = (m_cnt == per - 1);
    c_st  = next_mood(m_st, m_lvl);
    c_lvl = m_lvl;
    c_cnt = (m_cnt + 1) % 16;
    if (c_ev) begin
      c_lvl = (m_lvl + 8 > 127) ? 127 : m_lvl + 8;
      c_cnt = 0;
    end else if (c_tk) begin
      c_cnt = 0;
      if (m_lvl > 0) c_lvl = m_lvl - 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1  <= 0;
      m_s2  <= 0;
      m_h   <= 0;
      m_cnt <= 0;
      m_lvl <= 0;
      m_st  <= 0;
    end else begin
      m_s1  <= int'(stimulus);
      m_s2  <= m_s1;
      m_h   <= m_s2;
      m_cnt <= c_cnt;
      m_lvl <= c_lvl;
      m_st  <= c_st;
      q.push_back({7'(c_lvl), 2'(c_st)});
    end
  end

  exp_t       e;
  logic [1:0] prev_st = 2'b00;

  always @(negedge clk) begin
    e = '0;
    if (q.size() > 0) e = q.pop_front();
    else if (rst_n) check("sb_empty", 0, 1);
    if (!rst_n) e = '0;
    check("sb", int'({stress_level, stress_indicator, stress_state, panic}),
          int'({e.lvl, e.lvl[6:5], e.st, e.st == 2'b10}));
    check("jump", int'((prev_st == 2'd0 && stress_state == 2'd2) ||
                       (prev_st == 2'd2 && stress_state == 2'd0)), 0);
    prev_st <= stress_state;
  end

  initial begin
    repeat (6) begin
      @(negedge clk);
      stimulus = ~stimulus;
    end
    step(1);
    check("rst_lvl", int'(stress_level), 0);
    check("rst_st", int'(stress_state), 0);
    check("rst_panic", int'(panic), 0);
    check("rst_ind", int'(stress_indicator), 0);
    stimulus = 1'b0;
    #2 rst_n = 1'b1;
    step(4);

    stimulus = 1'b1;
    step(1);
    check("edge_k", int'(stress_level), 0);
    step(1);
    check("edge_k1", int'(stress_level), 0);
    step(1);
    check("edge_k2", int'(stress_level), 8);
    step(7);
    stimulus = 1'b0;
    check("hold_once", int'(stress_level), 8);
    step(2);

    repeat (16) pulse();
    check("sat", int'(stress_level), 127);
    check("sat_st", int'(stress_state), 2);
    check("sat_panic", int'(panic), 1);

    step(766);
    check("dec80", int'(stress_level), 80);
    step(1);
    check("dec79", int'(stress_level), 79);
    check("dec79_st", int'(stress_state), 2);
    step(1);
    check("dec_tense", int'(stress_state), 1);
    check("dec_unpanic", int'(panic), 0);
    step(1300);
    check("dec_zero", int'(stress_level), 0);
    check("dec_calm", int'(stress_state), 0);
    step(50);
    check("zero_hold", int'(stress_level), 0);

    repeat (5) pulse();
    check("lvl40", int'(stress_level), 40);
    step(12);
    stimulus = 1'b1;
    step(3);
    check("coin_lvl", int'(stress_level), 48);
    check("coin_cnt", int'(dut.r_cnt), 0);
    stimulus = 1'b0;
    step(15);
    check("coin_pre", int'(stress_level), 48);
    step(1);
    check("coin_tick", int'(stress_level), 47);

    stimulus = 1'b1;
    step(1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_lvl", int'(stress_level), 0);
    check("arst_sync", int'(dut.r_sync1), 0);
    check("arst_cnt", int'(dut.r_cnt), 0);
    stimulus = 1'b0;
    step(2);
    #2 rst_n = 1'b1;
    step(3);
    check("arst_drop", int'(stress_level), 0);

    asleep = 1'b1;
    repeat (2) pulse();
    check("slp16", int'(stress_level), 16);
    step(SLP_CYC - 2);
    check("slp_one", int'(stress_level), 1);
    step(1);
    check("slp_zero", int'(stress_level), 0);
    asleep = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
